csa_final_adder: RTL and testbench
==================================

Name: csa_final_adder

Overview:
- Pipelined carry-propagate adder that consumes the 48-bit redundant sum/carry pair produced by the 12-input CSA reduction tree of the mantissa multiplier.
- Resolves the pair into the 48-bit mantissa product and extracts the normalized 24-bit mantissa with guard/round/sticky bits and an exponent-increment flag for the rounding stage downstream.
- Two-stage pipeline with valid/ready handshake on both sides; full throughput when not back-pressured.

Parameters:
- WIDTH, 48, width of sum/carry inputs and product; must be even.
- MANT_W, 24, output mantissa width; fixed at WIDTH/2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  asynchronous active-low reset.
- in_valid  input  1  sum_vec/carry_vec hold a valid pair.
- in_ready  output  1  block accepts the pair this cycle.
- sum_vec  input  WIDTH  CSA sum vector.
- carry_vec  input  WIDTH  CSA carry vector, already aligned; added as-is.
- out_valid  output  1  outputs below are valid.
- out_ready  input  1  downstream accepts outputs this cycle.
- product  output  WIDTH  (sum_vec + carry_vec) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1 of the addition.
- mant  output  MANT_W  normalized mantissa, leading one at MSB when product != 0.
- guard_bit  output  1  first bit below mant LSB.
- round_bit  output  1  second bit below mant LSB.
- sticky_bit  output  1  OR of all remaining lower product bits.
- exp_inc  output  1  product[WIDTH-1] was set; exponent must increment by 1.

Behaviour:
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Data on sum_vec/carry_vec is only sampled on a transfer.
- Stage 1 register, on input transfer:
  - Add the lower WIDTH/2 bits of both vectors; store the WIDTH/2-bit low result and its carry.
  - Store the upper WIDTH/2 bits of both vectors unmodified.
  - Set valid v1.
- Stage 2 register:
  - Add the upper halves plus the stage-1 carry.
  - Concatenate with the low result to form product; the upper-half carry out becomes cout.
  - Perform normalization extraction from the complete product and register all outputs; out_valid = v2.
- Normalization, with P = product:
  - If P[47]=1: mant=P[47:24], guard=P[23], round=P[22], sticky=|P[21:0], exp_inc=1.
  - Else: mant=P[46:23], guard=P[22], round=P[21], sticky=|P[20:0], exp_inc=0.
  - P=0 yields all-zero outputs with exp_inc=0; no special-casing.
- Flow control (combinational):
  - adv2 = !v2 || out_ready.
  - in_ready = !v1 || adv2.
- Stage advance rules:
  - Stage 2 loads from stage 1 when adv2. v2 <= v1 on that edge, so stage 2 empties when stage 1 is empty.
  - Stage 1 loads on an input transfer. Otherwise v1 clears when stage 1 moved into stage 2 this cycle.
- Latency is exactly 2 cycles from input transfer to out_valid with no back-pressure; one result per cycle sustained.
- With out_valid=1 and out_ready=0, every output is held stable; at most 2 results are buffered.
- Simultaneous output transfer and input transfer in the same cycle is legal. No bubble is inserted and no data is lost or duplicated.
- Reset (asynchronous, any time, including mid-operation):
  - v1=v2=0, out_valid=0.
  - product, cout, mant, guard_bit, round_bit, sticky_bit, exp_inc all 0.
  - in_ready=1 while in reset and on the first cycle after release.
  - Pending data is discarded.
- No overflow detection beyond cout. cout is 0 for any legal mantissa product and is flagged for verification only.

Test Plan:
- sum=0x400000000000, carry=0, out_ready=1 -> 2 cycles later out_valid=1, product=0x400000000000, mant=0x800000, g=r=s=0, exp_inc=0, cout=0.
- sum=0x000000FFFFFF, carry=0x000000000001 (cross-half carry) -> product=0x000001000000, mant=0x000002, exp_inc=0, sticky=0, cout=0.
- sum=0xFFFFFE000000, carry=0x000000000001 -> product=0xFFFFFE000001, exp_inc=1, mant=0xFFFFFE, guard=0, round=0, sticky=1.
- sum=0xFFFFFFFFFFFF, carry=0x000000000002 -> product=0x000000000001, cout=1, mant=0, sticky=1.
- Back-pressure: 4 back-to-back inputs with out_ready=0 for 5 cycles:
  - in_ready falls after 2 accepted; outputs held stable.
  - After out_ready=1, all 4 results emerge in order, one per cycle, with no loss or duplication.
- Reset mid-operation: assert nreset with v1=v2=1 -> out_valid=0 and all outputs 0 asynchronously; after release, in_ready=1 and a new input produces its result 2 cycles later.

Source files
------------

// File: rtl/csa_final_adder.sv
// Two-stage carry-propagate adder resolving a redundant sum/carry pair into the
// mantissa product, then extracting the normalized mantissa with guard/round/sticky.
module csa_final_adder #(
    parameter int WIDTH  = 48,
    parameter int MANT_W = WIDTH / 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  sum_vec,
    input  logic [WIDTH-1:0]  carry_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  product,
    output logic              cout,
    output logic [MANT_W-1:0] mant,
    output logic              guard_bit,
    output logic              round_bit,
    output logic              sticky_bit,
    output logic              exp_inc
);

    localparam int HALF = WIDTH / 2;

    // Valid/ready: a transfer happens on a rising edge where valid && ready;
    // data is only sampled on a transfer and held stable while valid && !ready.

    logic              v1_q, v1_d;
    logic [HALF-1:0]   lo_sum_q, lo_sum_d;
    logic              lo_c_q, lo_c_d;
    logic [HALF-1:0]   hi_s_q, hi_s_d;
    logic [HALF-1:0]   hi_c_q, hi_c_d;

    logic              v2_q, v2_d;
    logic [WIDTH-1:0]  product_q, product_d;
    logic              cout_q, cout_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic              guard_q, guard_d;
    logic              round_q, round_d;
    logic              sticky_q, sticky_d;
    logic              exp_inc_q, exp_inc_d;

    logic              adv2;
    logic              in_xfer;
    logic [HALF:0]     lo_add;
    logic [HALF:0]     hi_add;
    logic [WIDTH-1:0]  full_p;
    logic [MANT_W-1:0] mant_n;
    logic              guard_n, round_n, sticky_n, exp_inc_n;

    assign adv2     = !v2_q || out_ready;
    assign in_ready = !v1_q || adv2;
    assign in_xfer  = in_valid && in_ready;

    assign lo_add = {1'b0, sum_vec[HALF-1:0]} + {1'b0, carry_vec[HALF-1:0]};

    always_comb begin
        v1_d     = v1_q;
        lo_sum_d = lo_sum_q;
        lo_c_d   = lo_c_q;
        hi_s_d   = hi_s_q;
        hi_c_d   = hi_c_q;
        if (in_xfer) begin
            v1_d     = 1'b1;
            lo_sum_d = lo_add[HALF-1:0];
            lo_c_d   = lo_add[HALF];
            hi_s_d   = sum_vec[WIDTH-1:HALF];
            hi_c_d   = carry_vec[WIDTH-1:HALF];
        end else if (adv2) begin
            v1_d = 1'b0;
        end
    end

    // Upper half completes the addition using the low-half carry captured in stage 1.
    assign hi_add = {1'b0, hi_s_q} + {1'b0, hi_c_q} + {{HALF{1'b0}}, lo_c_q};
    assign full_p = {hi_add[HALF-1:0], lo_sum_q};

    always_comb begin
        mant_n    = '0;
        guard_n   = 1'b0;
        round_n   = 1'b0;
        sticky_n  = 1'b0;
        exp_inc_n = 1'b0;
        if (full_p[WIDTH-1]) begin
            mant_n    = full_p[WIDTH-1 -: MANT_W];
            guard_n   = full_p[WIDTH-MANT_W-1];
            round_n   = full_p[WIDTH-MANT_W-2];
            sticky_n  = |full_p[WIDTH-MANT_W-3:0];
            exp_inc_n = 1'b1;
        end else begin
            mant_n    = full_p[WIDTH-2 -: MANT_W];
            guard_n   = full_p[WIDTH-MANT_W-2];
            round_n   = full_p[WIDTH-MANT_W-3];
            sticky_n  = |full_p[WIDTH-MANT_W-4:0];
        end
    end

    // Stage 2 only captures new data when stage 1 actually holds a pair.
    always_comb begin
        v2_d      = v2_q;
        product_d = product_q;
        cout_d    = cout_q;
        mant_d    = mant_q;
        guard_d   = guard_q;
        round_d   = round_q;
        sticky_d  = sticky_q;
        exp_inc_d = exp_inc_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                product_d = full_p;
                cout_d    = hi_add[HALF];
                mant_d    = mant_n;
                guard_d   = guard_n;
                round_d   = round_n;
                sticky_d  = sticky_n;
                exp_inc_d = exp_inc_n;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v1_q      <= 1'b0;
            lo_sum_q  <= '0;
            lo_c_q    <= 1'b0;
            hi_s_q    <= '0;
            hi_c_q    <= '0;
            v2_q      <= 1'b0;
            product_q <= '0;
            cout_q    <= 1'b0;
            mant_q    <= '0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
            exp_inc_q <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            lo_sum_q  <= lo_sum_d;
            lo_c_q    <= lo_c_d;
            hi_s_q    <= hi_s_d;
            hi_c_q    <= hi_c_d;
            v2_q      <= v2_d;
            product_q <= product_d;
            cout_q    <= cout_d;
            mant_q    <= mant_d;
            guard_q   <= guard_d;
            round_q   <= round_d;
            sticky_q  <= sticky_d;
            exp_inc_q <= exp_inc_d;
        end
    end

    assign out_valid  = v2_q;
    assign product    = product_q;
    assign cout       = cout_q;
    assign mant       = mant_q;
    assign guard_bit  = guard_q;
    assign round_bit  = round_q;
    assign sticky_bit = sticky_q;
    assign exp_inc    = exp_inc_q;

endmodule

// File: tb/tb_csa_final_adder.sv
// Bench for csa_final_adder: directed test-plan vectors, back-pressure, reset
// mid-flight and random traffic, with a queue scoreboard for every output transfer.
module tb_csa_final_adder;

    localparam int W  = 48;
    localparam int M  = 24;
    localparam int EW = W + M + 5;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  sum_vec = '0;
    logic [W-1:0]  carry_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  product;
    logic          cout;
    logic [M-1:0]  mant;
    logic          guard_bit, round_bit, sticky_bit, exp_inc;

    int checks = 0;
    int errors = 0;
    int sb_checks = 0;
    int sb_errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] sb_exp;
    logic [EW-1:0] got;

    csa_final_adder #(.WIDTH(W), .MANT_W(M)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_vec    (sum_vec),
        .carry_vec  (carry_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .cout       (cout),
        .mant       (mant),
        .guard_bit  (guard_bit),
        .round_bit  (round_bit),
        .sticky_bit (sticky_bit),
        .exp_inc    (exp_inc)
    );

    always #5 clk = ~clk;

    assign got = {cout, product, mant, guard_bit, round_bit, sticky_bit, exp_inc};

    // Reference: full-width add then the two-case normalization, fixed 48/24 indices.
    function automatic logic [EW-1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W:0]   full;
        logic [W-1:0] p;
        logic [M-1:0] m;
        logic         g, r, st, e;
        full = {1'b0, s} + {1'b0, c};
        p = full[W-1:0];
        if (p[47]) begin
            m = p[47:24]; g = p[23]; r = p[22]; st = |p[21:0]; e = 1'b1;
        end else begin
            m = p[46:23]; g = p[22]; r = p[21]; st = |p[20:0]; e = 1'b0;
        end
        return {full[W], p, m, g, r, st, e};
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so both handshakes are sampled here.
    always @(negedge clk) begin
        if (!nreset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                sb_checks++;
                if (exp_q.size() == 0) begin
                    sb_errors++;
                    $display("FAIL sb_unexpected_output: got %h, required no output", got);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (got !== sb_exp) begin
                        sb_errors++;
                        $display("FAIL sb_output: got %h, required %h", got, sb_exp);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(sum_vec, carry_vec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] s, input logic [W-1:0] c);
        logic acc;
        acc = 1'b0;
        sum_vec = s;
        carry_vec = c;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0b, required 1", acc);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, got} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {out_valid, got});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        nreset = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b, required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0]  s_t[4];
        logic [W-1:0]  c_t[4];
        logic [EW-1:0] e_t[4];
        s_t[0] = 48'h400000000000; c_t[0] = 48'h000000000000;
        e_t[0] = {1'b0, 48'h400000000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0};
        s_t[1] = 48'h000000FFFFFF; c_t[1] = 48'h000000000001;
        e_t[1] = {1'b0, 48'h000001000000, 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0};
        s_t[2] = 48'hFFFFFE000000; c_t[2] = 48'h000000000001;
        e_t[2] = {1'b0, 48'hFFFFFE000001, 24'hFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1};
        s_t[3] = 48'hFFFFFFFFFFFF; c_t[3] = 48'h000000000002;
        e_t[3] = {1'b1, 48'h000000000001, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(s_t[i], c_t[i]);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_latency1: out_valid %b, required 0", i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed%0d_latency2: out_valid %b, required 1", i, out_valid);
            end
            checks++;
            if (got !== e_t[i]) begin
                errors++;
                $display("FAIL directed%0d_value: got %h, required %h", i, got, e_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sum_vec = W'({$urandom(), $urandom()});
            carry_vec = W'({$urandom(), $urandom()});
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready%0d: got %b, required 1", i, in_ready);
            end
            tick();
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_out_valid%0d: got %b, required 1", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last_valid: got %b, required 1", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] held;
        logic [W-1:0]  d[4];
        for (int i = 0; i < 4; i++) d[i] = W'({$urandom(), $urandom()}) | 48'h400000000000;
        out_ready = 1'b0;
        in_valid = 1'b1;
        sum_vec = d[0]; carry_vec = d[3];
        tick();
        sum_vec = d[1]; carry_vec = d[2];
        tick();
        sum_vec = d[2]; carry_vec = d[1];
        held = got;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_full%0d: in_ready %b out_valid %b, required 0 1", i, in_ready, out_valid);
            end
            checks++;
            if (got !== held) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h, required %h", i, got, held);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        sum_vec = d[3]; carry_vec = d[0];
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_drain%0d: out_valid %b, required 1", i, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_empty: out_valid %b pending %0d, required 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        sum_vec = 48'h123456789ABC; carry_vec = 48'h0F0F0F0F0F0F;
        tick();
        sum_vec = 48'h7654321FEDCB;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rm_fill: out_valid %b in_ready %b, required 1 0", out_valid, in_ready);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({out_valid, got} !== '0) begin
            errors++;
            $display("FAIL rm_async_clear: got %h, required 0", {out_valid, got});
        end
        tick();
        tick();
        nreset = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_release: in_ready %b out_valid %b, required 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        drive(48'h9ABCDEF01234, 48'h111111111111);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_latency1: out_valid %b, required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_latency2: out_valid %b, required 1", out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        int sent;
        sent = 0;
        for (int i = 0; i < 400 && sent < 40; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sum_vec = W'({$urandom(), $urandom()}) >> $urandom_range(0, 3);
            carry_vec = ($urandom_range(0, 3) == 0) ? '0 : W'({$urandom(), $urandom()}) >> $urandom_range(0, 4);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick();
        checks++;
        if (sent != 40 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: sent %0d pending %0d, required 40 0", sent, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        tick();
        checks += sb_checks;
        errors += sb_errors;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
